// File: rtl/lif_spike_encoder_if.sv
// Bundle of the strobe, sample, control and spike signals exchanged between the
// metric source (master) and the LIF spike encoder (slave).
//
// Signals:
//   line_sync      strobe, one cycle per new metric set
//   din            packed signed samples, lane i = din[i*DW +: DW]
//   thresh         packed unsigned thresholds, 0 disables the lane
//   sub_reset      1: subtract threshold on fire, 0: clear accumulator on fire
//   leak_en        apply leak before integration
//   refrac_cycles  strobes ignored after a fire
//   sat_clr        clears all saturation flags
//   spike          single-cycle spike pulses (encoder output)
//   spike_sign     sign of the sample that caused the fire (encoder output)
//   sat_flag       sticky accumulator-saturation flags (encoder output)
interface lif_spike_encoder_if #(
    parameter int unsigned NCH      = 3,
    parameter int unsigned DW       = 24,
    parameter int unsigned REFRAC_W = 4
);
    logic                  line_sync;
    logic [NCH*DW-1:0]     din;
    logic [NCH*DW-1:0]     thresh;
    logic                  sub_reset;
    logic                  leak_en;
    logic [REFRAC_W-1:0]   refrac_cycles;
    logic                  sat_clr;
    logic [NCH-1:0]        spike;
    logic [NCH-1:0]        spike_sign;
    logic [NCH-1:0]        sat_flag;

    modport master (
        output line_sync, din, thresh, sub_reset, leak_en, refrac_cycles, sat_clr,
        input  spike, spike_sign, sat_flag
    );

    modport slave (
        input  line_sync, din, thresh, sub_reset, leak_en, refrac_cycles, sat_clr,
        output spike, spike_sign, sat_flag
    );
endinterface

// File: rtl/lif_spike_encoder.sv
// Multi-channel leaky integrate-and-fire rate encoder. Each lane integrates |din|
// once per line_sync strobe (optionally leaking first), fires a registered
// single-cycle spike when the accumulator reaches its threshold, then either
// subtracts the threshold or clears, and ignores a programmable number of strobes.
//
// Optional feature macro: SPIKE_SIGN_EN
//   defined   -> spike_sign captures the sign of the firing sample per lane
//   undefined -> spike_sign is tied to 0 and no register is built
//
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous reset, active-high
//   bus  slave modport of lif_spike_encoder_if (strobe, samples, controls, spikes,
//        spike_sign, sat_flag)
module lif_spike_encoder #(
    parameter int unsigned NCH        = 3,
    parameter int unsigned DW         = 24,
    parameter int unsigned AW         = 25,
    parameter int unsigned LEAK_SHIFT = 4,
    parameter int unsigned REFRAC_W   = 4
) (
    input logic                 clk,
    input logic                 rst,
    lif_spike_encoder_if.slave  bus
);

    logic [AW-1:0]       acc_q   [NCH];
    logic [AW-1:0]       acc_d   [NCH];
    logic [REFRAC_W-1:0] refr_q  [NCH];
    logic [REFRAC_W-1:0] refr_d  [NCH];
    logic [AW-1:0]       sat_sum [NCH];
    logic [AW-1:0]       resid   [NCH];

    logic [NCH-1:0] spike_q, spike_d;
    logic [NCH-1:0] sat_q, sat_d;
    logic [NCH-1:0] ovf;      // integration overflowed AW bits on this strobe
    logic [NCH-1:0] fire;     // saturated sum reached the threshold
    logic [NCH-1:0] thr_zero; // lane disabled
    logic [NCH-1:0] take;     // strobe accepted for integration on this lane
    logic [NCH-1:0] sgn;      // sign bit of the current sample

    // Per-lane datapath
    for (genvar i = 0; i < NCH; i++) begin : g_lane
        logic [DW-1:0] smp;
        logic [DW-1:0] thr;
        logic [DW-1:0] mag;
        logic [AW-1:0] leaked;
        logic [AW-1:0] thr_ext;
        logic [AW:0]   sum;

        assign smp = bus.din[i*DW +: DW];
        assign thr = bus.thresh[i*DW +: DW];

        // Two's-complement negate in DW bits; -2^(DW-1) yields 2^(DW-1) as unsigned.
        assign mag = smp[DW-1] ? (~smp + DW'(1)) : smp;

        assign leaked  = bus.leak_en ? (acc_q[i] - (acc_q[i] >> LEAK_SHIFT)) : acc_q[i];
        assign sum     = {1'b0, leaked} + {{(AW + 1 - DW){1'b0}}, mag};
        assign ovf[i]  = sum[AW];
        assign sat_sum[i] = sum[AW] ? {AW{1'b1}} : sum[AW-1:0];

        assign thr_ext     = {{(AW - DW){1'b0}}, thr};
        assign fire[i]     = (sat_sum[i] >= thr_ext);
        assign thr_zero[i] = (thr == '0);
        assign resid[i]    = bus.sub_reset ? (sat_sum[i] - thr_ext) : '0;
        assign sgn[i]      = smp[DW-1];

        assign take[i] = bus.line_sync && !thr_zero[i] && (refr_q[i] == '0);
    end

    // Next-state
    always_comb begin
        acc_d   = acc_q;
        refr_d  = refr_q;
        spike_d = take & fire;
        // Clear first, then new saturation sets: set wins over clear.
        sat_d   = (sat_q & ~{NCH{bus.sat_clr}}) | (take & ovf);
        if (bus.line_sync) begin
            for (int i = 0; i < NCH; i++) begin
                if (thr_zero[i]) begin
                    acc_d[i]  = '0;
                    refr_d[i] = '0;
                end else if (refr_q[i] != '0) begin
                    acc_d[i]  = '0;
                    refr_d[i] = refr_q[i] - REFRAC_W'(1);
                end else if (fire[i]) begin
                    acc_d[i]  = resid[i];
                    refr_d[i] = bus.refrac_cycles;
                end else begin
                    acc_d[i]  = sat_sum[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]  <= '0;
                refr_q[i] <= '0;
            end
            spike_q <= '0;
            sat_q   <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]  <= acc_d[i];
                refr_q[i] <= refr_d[i];
            end
            spike_q <= spike_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.spike    = spike_q;
    assign bus.sat_flag = sat_q;

`ifdef SPIKE_SIGN_EN
    logic [NCH-1:0] sign_q, sign_d;

    // Holds between fires; only meaningful while the lane's spike is high.
    always_comb begin
        sign_d = sign_q;
        for (int i = 0; i < NCH; i++) begin
            if (spike_d[i]) begin
                sign_d[i] = sgn[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q <= '0;
        end else begin
            sign_q <= sign_d;
        end
    end

    assign bus.spike_sign = sign_q;
`else
    logic unused_sgn;
    assign unused_sgn     = ^sgn;
    assign bus.spike_sign = '0;
`endif

endmodule

// File: tb/tb_lif_spike_encoder.sv
module tb_lif_spike_encoder;
    localparam int NCH = 3;
    localparam int DW  = 24;
    localparam int AW  = 25;
    localparam int LS  = 4;
    localparam int RW  = 4;
    localparam longint ACC_MAX = (64'sd1 <<< AW) - 1;

`ifdef SPIKE_SIGN_EN
    localparam bit SIGN_EN = 1'b1;
`else
    localparam bit SIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lif_spike_encoder_if #(.NCH(NCH), .DW(DW), .REFRAC_W(RW)) bus ();

    lif_spike_encoder #(
        .NCH(NCH), .DW(DW), .AW(AW), .LEAK_SHIFT(LS), .REFRAC_W(RW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NCH-1:0] spike;
        logic [NCH-1:0] sign;
        logic [NCH-1:0] sat;
        int             idx;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_no  = 0;

    // Reference model state (plain integer arithmetic)
    longint         m_acc  [NCH];
    int             m_refr [NCH];
    logic [NCH-1:0] m_sat;
    logic [NCH-1:0] m_sign;
    logic [NCH-1:0] m_spike;

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_acc[i]  = 0;
            m_refr[i] = 0;
        end
        m_sat   = '0;
        m_sign  = '0;
        m_spike = '0;
    endfunction

    function automatic void model_step(bit ls, logic [NCH*DW-1:0] d, logic [NCH*DW-1:0] th,
                                       bit sr, bit le, int rc, bit sc);
        longint v, a, t, l, s;
        logic [DW-1:0] lane;
        m_spike = '0;
        m_sat   = m_sat & ~{NCH{sc}};
        if (ls) begin
            for (int i = 0; i < NCH; i++) begin
                lane = d[i*DW +: DW];
                v    = longint'($signed(lane));
                a    = (v < 0) ? -v : v;
                lane = th[i*DW +: DW];
                t    = longint'(lane);
                if (t == 0) begin
                    m_acc[i]  = 0;
                    m_refr[i] = 0;
                end else if (m_refr[i] > 0) begin
                    m_refr[i] = m_refr[i] - 1;
                    m_acc[i]  = 0;
                end else begin
                    l = le ? (m_acc[i] - m_acc[i] / (64'sd1 <<< LS)) : m_acc[i];
                    s = l + a;
                    if (s > ACC_MAX) begin
                        s        = ACC_MAX;
                        m_sat[i] = 1'b1;
                    end
                    if (s >= t) begin
                        m_spike[i] = 1'b1;
                        m_acc[i]   = sr ? (s - t) : 0;
                        m_refr[i]  = rc;
                        m_sign[i]  = (v < 0);
                    end else begin
                        m_acc[i] = s;
                    end
                end
            end
        end
    endfunction

    task automatic check(string name, int idx, logic [NCH-1:0] act, logic [NCH-1:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s (step %0d): got %b expected %b", name, idx, act, want);
    endtask

    // Apply one cycle of inputs and queue the expected outputs for the next cycle.
    task automatic drive(bit ls, logic [NCH*DW-1:0] d, logic [NCH*DW-1:0] th,
                         bit sr, bit le, logic [RW-1:0] rc, bit sc);
        exp_t e;
        @(negedge clk);
        bus.line_sync     = ls;
        bus.din           = d;
        bus.thresh        = th;
        bus.sub_reset     = sr;
        bus.leak_en       = le;
        bus.refrac_cycles = rc;
        bus.sat_clr       = sc;
        model_step(ls, d, th, sr, le, int'(rc), sc);
        e.spike = m_spike;
        e.sign  = SIGN_EN ? m_sign : '0;
        e.sat   = m_sat;
        e.idx   = step_no;
        step_no++;
        exp_q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, bus.din, bus.thresh, bus.sub_reset, bus.leak_en, bus.refrac_cycles, 1'b0);
    endtask

    // Strobe with all thresholds 0: clears accumulators and refractory counters.
    task automatic clear_lanes();
        drive(1'b1, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            #3;
            n++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic [NCH*DW-1:0] rep(logic [DW-1:0] x);
        return {x, x, x};
    endfunction

    // Monitor: outputs of each cycle are compared against the oldest queued entry.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("spike", e.idx, bus.spike, e.spike);
                check("spike_sign", e.idx, bus.spike_sign, e.sign);
                check("sat_flag", e.idx, bus.sat_flag, e.sat);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NCH*DW-1:0] d, th;
        logic [DW-1:0]     x;
        int                v, r;

        bus.line_sync     = 1'b0;
        bus.din           = '0;
        bus.thresh        = '0;
        bus.sub_reset     = 1'b0;
        bus.leak_en       = 1'b0;
        bus.refrac_cycles = '0;
        bus.sat_clr       = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_spike", -1, bus.spike, '0);
        check("reset_sign", -1, bus.spike_sign, '0);
        check("reset_sat", -1, bus.sat_flag, '0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-reset mode, +30 per strobe against 100
        clear_lanes();
        repeat (12) drive(1'b1, rep(24'd30), rep(24'd100), 1'b0, 1'b0, '0, 1'b0);
        idle(1);

        // Subtract mode, 40 per strobe against 100
        clear_lanes();
        repeat (10) drive(1'b1, rep(24'd40), rep(24'd100), 1'b1, 1'b0, '0, 1'b0);
        idle(1);

        // Leak: 50 -> 47 -> 45, then probe the residue with thresholds 45/45/46
        clear_lanes();
        drive(1'b1, rep(24'd50), rep(24'd1000), 1'b0, 1'b0, '0, 1'b0);
        repeat (2) drive(1'b1, rep(24'd0), rep(24'd1000), 1'b0, 1'b1, '0, 1'b0);
        drive(1'b1, rep(24'd0), {24'd46, 24'd45, 24'd45}, 1'b0, 1'b0, '0, 1'b0);
        idle(1);

        // Refractory period of 2 strobes
        clear_lanes();
        repeat (7) drive(1'b1, rep(24'd200), rep(24'd100), 1'b0, 1'b0, 4'd2, 1'b0);
        idle(1);

        // Most negative input, lane 1 disabled
        clear_lanes();
        repeat (3) drive(1'b1, rep(24'h800000), {24'h800000, 24'd0, 24'h800000},
                         1'b0, 1'b0, '0, 1'b0);
        idle(1);

        // Saturation and sat_clr priority
        clear_lanes();
        repeat (5) drive(1'b1, rep(24'h7FFFFF), rep(24'd1), 1'b1, 1'b0, '0, 1'b0);
        drive(1'b0, rep(24'h7FFFFF), rep(24'd1), 1'b1, 1'b0, '0, 1'b1);
        drive(1'b1, rep(24'h7FFFFF), rep(24'd1), 1'b1, 1'b0, '0, 1'b1);
        drive(1'b1, rep(24'h7FFFFF), rep(24'd1), 1'b1, 1'b0, '0, 1'b0);
        drain();

        // Asynchronous reset mid-run discards residue and flags
        clear_lanes();
        repeat (2) drive(1'b1, rep(24'd40), rep(24'd100), 1'b1, 1'b0, '0, 1'b0);
        drain();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_spike", -2, bus.spike, '0);
        check("midrst_sign", -2, bus.spike_sign, '0);
        check("midrst_sat", -2, bus.sat_flag, '0);
        #2;
        rst = 1'b0;
        model_reset();
        repeat (4) drive(1'b1, rep(24'd40), rep(24'd100), 1'b1, 1'b0, '0, 1'b0);
        idle(1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NCH; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0) x = DW'($urandom);
                else begin
                    v = $urandom_range(0, 600) - 300;
                    x = v[DW-1:0];
                end
                d[i*DW +: DW] = x;
                r = $urandom_range(0, 9);
                if (r == 0) x = '0;
                else if (r == 1) x = DW'($urandom);
                else x = DW'($urandom_range(1, 600));
                th[i*DW +: DW] = x;
            end
            drive($urandom_range(0, 3) != 0, d, th, 1'($urandom), 1'($urandom),
                  RW'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
